// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it, divide ops complete at once and flag illegal.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        f3_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              sign_q_reg;
  logic              busy_reg, done_reg, illegal_reg, illegal_next;
  logic [XLEN-1:0]   result_reg;

  logic              a_signed, b_signed, neg_a, neg_b, is_div, accept;
  logic [XLEN-1:0]   mag_a, mag_b, mul_add, mul_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = a_signed & op_a[XLEN-1];
    neg_b    = b_signed & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    is_div   = funct3[2];
    // DONE accepts like IDLE so back-to-back ops lose no cycle.
    accept   = start & ~kill & ((state_reg == S_IDLE) || (state_reg == S_DONE));
  end

  // Multiplier lives in the low half of the accumulator and shifts out as the product shifts in.
  always_comb begin
    mul_add  = acc_reg[0] ? mcand_reg : '0;
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mul_add};
    mul_step = {mul_sum, acc_reg[XLEN-1:1]};
    prod_fix = sign_q_reg ? -acc_reg : acc_reg;
    mul_res  = (f3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] rem_reg;
  logic            sign_r_reg;
  logic            div_zero, div_ok;
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix;

  // Quotient bits shift into the low accumulator half as dividend bits leave its top.
  always_comb begin
    div_zero  = is_div && (op_b == '0);
    div_shift = {rem_reg, acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_ok    = ~div_diff[XLEN];
    rem_step  = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_step  = {acc_reg[XLEN-2:0], div_ok};
    quo_fix   = sign_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    rem_fix   = sign_r_reg ? -rem_reg : rem_reg;
    fix_res   = f3_reg[2] ? (f3_reg[1] ? rem_fix : quo_fix) : mul_res;
    illegal_next = 1'b0;
  end
`else
  always_comb begin
    fix_res      = f3_reg[2] ? '0 : mul_res;
    illegal_next = accept & is_div;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (accept) begin
`ifdef MULDIV_DIV_EN
          state_next = div_zero ? S_FIX : S_CALC;
`else
          state_next = is_div ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt_reg == CNT_W'(XLEN - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      f3_reg      <= '0;
      mcand_reg   <= '0;
      acc_reg     <= '0;
      sign_q_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      result_reg  <= '0;
`ifdef MULDIV_DIV_EN
      rem_reg     <= '0;
      sign_r_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      busy_reg    <= (state_next == S_CALC) || (state_next == S_FIX);
      done_reg    <= (state_next == S_DONE);
      illegal_reg <= illegal_next;
      if (accept) begin
        f3_reg     <= funct3;
        cnt_reg    <= '0;
        mcand_reg  <= mag_b;
        acc_reg    <= {{XLEN{1'b0}}, mag_a};
        sign_q_reg <= neg_a ^ neg_b;
`ifdef MULDIV_DIV_EN
        rem_reg    <= '0;
        sign_r_reg <= neg_a;
        // Zero divisor: preload the architectural answers so FIX passes them through unchanged.
        if (div_zero) begin
          acc_reg    <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
          rem_reg    <= op_a;
          sign_q_reg <= 1'b0;
          sign_r_reg <= 1'b0;
        end
`else
        if (is_div) result_reg <= '0;
`endif
      end else if (state_reg == S_CALC) begin
        cnt_reg <= cnt_reg + 1'b1;
`ifdef MULDIV_DIV_EN
        if (f3_reg[2]) begin
          acc_reg <= {{XLEN{1'b0}}, quo_step};
          rem_reg <= rem_step;
        end else begin
          acc_reg <= mul_step;
        end
`else
        acc_reg <= mul_step;
`endif
      end else if ((state_reg == S_FIX) && !kill) begin
        result_reg <= fix_res;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table, corner sequences and
// randomized ops against an arithmetic reference model; follows the MULDIV_DIV_EN build choice.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done, illegal;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_exp = 32'h0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Architectural results computed with wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b);
    if (f3[2] && !DIV_EN) return 1;
    if (f3[2] && b == 0) return 2;
    return 34;
  endfunction

  // Call right after the accepting edge (+#1); returns the cycle index of done, 0 if none.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic exp_ill;
    exp_ill = f3[2] && !DIV_EN;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check({name, " busy_c1"}, busy, exp_lat > 1);
    if (done) lat = 1;
    else begin
      wait_done(lat);
      if (lat != 0) lat = lat + 1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result, exp_res);
    check({name, " illegal"}, illegal, exp_ill);
    check({name, " busy_done"}, busy, 0);
    last_exp = exp_res;
    $display("op %s f3=%0d a=%h b=%h -> result=%h illegal=%0b latency=%0d", name, f3, a, b, result, illegal, lat);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[14];
  int   lat, nd;
  logic [31:0] ea, eb, er;
  logic [2:0]  ef;

  initial begin
    tbl[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    tbl[1]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 34};
    tbl[2]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    tbl[3]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    tbl[4]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34};
    tbl[5]  = '{3'd5, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 2};
    tbl[6]  = '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 2};
    tbl[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    tbl[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    tbl[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    tbl[10] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    tbl[11] = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34};
    tbl[12] = '{3'd4, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 2};
    tbl[13] = '{3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 34};

    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset illegal", illegal, 0);
    check("reset result", result, 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].f3[2] && !DIV_EN) run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, 32'h0, 1);
      else run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
    end

    // Kill in cycle 10 of a MUL: idle in cycle 11, no done, result untouched.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'h0000_1234; op_b = 32'h0000_5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    check("kill busy_c11", busy, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("kill no_done", nd, 0);
    check("kill result_kept", result, last_exp);
    $display("op kill_mul result=%h done_count=%0d", result, nd);

    // Kill together with start in idle: start dropped.
    @(negedge clk);
    funct3 = 3'd3; op_a = 32'h5; op_b = 32'h7; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("killstart busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("killstart no_done", nd, 0);
    $display("op kill_with_start result=%h done_count=%0d", result, nd);

    // Start pulse in cycle 5 of a running MULHU is ignored, not queued.
    ea = 32'hDEAD_BEEF; eb = 32'h1234_5678; ef = 3'd3;
    er = ref_model(ef, ea, eb);
    @(negedge clk);
    funct3 = ef; op_a = ea; op_b = eb; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 funct3 = 3'd5; op_a = 32'h9; op_b = 32'h0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    if (lat != 0) lat = lat + 5;
    check("ignstart latency", lat, 34);
    check("ignstart result", result, er);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ignstart not_queued", nd, 0);
    $display("op ignored_start result=%h latency=%0d extra_done=%0d", result, lat, nd);

    // Back-to-back: next start issued in the done cycle.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    check("b2b first result", result, 32'd15);
    ea = $urandom; eb = $urandom; ef = 3'd2;
    er = ref_model(ef, ea, eb);
    funct3 = ef; op_a = ea; op_b = eb; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    check("b2b second latency", lat, 34);
    check("b2b second result", result, er);
    $display("op back_to_back second result=%h latency=%0d", result, lat);

    // Synchronous reset mid-operation.
    @(negedge clk);
    funct3 = 3'd1; op_a = 32'h7777_0000; op_b = 32'h0000_3333; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset result", result, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midreset no_done", nd, 0);
    $display("op mid_reset result=%h done_count=%0d", result, nd);

    for (int i = 0; i < 40; i++) begin
      ef = 3'($urandom_range(0, 7));
      ea = pick_operand();
      eb = pick_operand();
      if (ef[2] && !DIV_EN) er = 32'h0;
      else er = ref_model(ef, ea, eb);
      run_op($sformatf("rnd%0d", i), ef, ea, eb, er, exp_latency(ef, eb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
